// File: rtl/serv_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serv_rvfi_pkg
// Purpose  : Shared definitions for the RVFI branch monitor: the branch
//            opcode, the conditional-branch funct3 encodings and the
//            monitor state type.
// Revision : 1.0 - initial release
// ============================================================================
package serv_rvfi_pkg;

    // insn[6:2] of every RV32I conditional branch
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // funct3 encodings of the six legal conditional branches
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_e;

    // Monitor state: warm-up ignores retirements, check compares them,
    // fail is terminal until reset.
    typedef enum logic [1:0] {
        ST_WARMUP = 2'b00,
        ST_CHECK  = 2'b01,
        ST_FAIL   = 2'b10
    } mon_state_e;

endpackage
`default_nettype wire

// File: rtl/serv_branch_eval.sv
`default_nettype none
// ============================================================================
// Module   : serv_branch_eval
// Purpose  : Combinational reference evaluation of one retired instruction
//            as an RV32I conditional branch.
// Ports    : insn      - retired instruction word
//            rs1, rs2  - source operand values
//            pc_rdata  - PC of the retired instruction
//            legal     - insn is a conditional branch with a legal funct3
//            taken     - branch condition holds
//            exp_pc    - architecturally expected next PC (wraps mod 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module serv_branch_eval
    import serv_rvfi_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] pc_rdata,
    output logic        legal,
    output logic        taken,
    output logic [31:0] exp_pc
);

    logic [2:0]  w_funct3;
    logic [31:0] w_imm;
    logic        w_funct3_ok;
    logic        w_unused;

    assign w_funct3 = insn[14:12];

    // B-type immediate, sign-extended; bit 0 is always zero
    assign w_imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};

    // Register specifier fields do not affect the reference result
    assign w_unused = &{1'b0, insn[24:15]};

    always_comb begin
        w_funct3_ok = 1'b1;
        taken       = 1'b0;
        case (w_funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: w_funct3_ok = 1'b0;
        endcase
    end

    assign legal  = (insn[6:2] == OPC_BRANCH) && (insn[1:0] == 2'b11) && w_funct3_ok;

    // Carry out of bit 31 is dropped so PC wrap-around is accepted
    assign exp_pc = taken ? (pc_rdata + w_imm) : (pc_rdata + 32'd4);

endmodule
`default_nettype wire

// File: rtl/rvfi_branch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_branch_monitor
// Purpose  : Watches the RVFI retirement stream and checks every retired
//            conditional branch's reported next PC against a reference
//            evaluation. The first mismatch is captured and latched.
// Ports    : clk, i_rst        - clock, synchronous active-high reset
//            rvfi_*            - retirement trace from the core
//            o_armed           - checking is active
//            o_err             - sticky mismatch flag
//            o_err_pc/insn     - PC and instruction of first mismatch
//            o_branch_cnt      - branches checked (saturating)
//            o_taken_cnt       - checked branches taken (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_branch_monitor
    import serv_rvfi_pkg::*;
#(
    parameter int WARMUP = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             rvfi_valid,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic [31:0]      rvfi_rs1_rdata,
    input  logic [31:0]      rvfi_rs2_rdata,
    input  logic [31:0]      rvfi_pc_rdata,
    input  logic [31:0]      rvfi_pc_wdata,
    output logic             o_armed,
    output logic             o_err,
    output logic [31:0]      o_err_pc,
    output logic [31:0]      o_err_insn,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    // A zero-width counter is not legal, so WARMUP=0 keeps a single
    // (unused) bit.
    localparam int c_WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WARMUP - 1);
    localparam mon_state_e c_RST_STATE = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;

    mon_state_e            r_state;
    mon_state_e            w_next_state;
    logic [c_WCNT_W-1:0]   r_wcnt;
    logic                  r_err;
    logic [31:0]           r_err_pc;
    logic [31:0]           r_err_insn;
    logic [CNT_W-1:0]      r_branch_cnt;
    logic [CNT_W-1:0]      r_taken_cnt;

    logic                  w_legal;
    logic                  w_taken;
    logic [31:0]           w_exp_pc;
    logic                  w_checkable;
    logic                  w_mismatch;
    logic                  w_do_check;

    serv_branch_eval u_eval (
        .insn     (rvfi_insn),
        .rs1      (rvfi_rs1_rdata),
        .rs2      (rvfi_rs2_rdata),
        .pc_rdata (rvfi_pc_rdata),
        .legal    (w_legal),
        .taken    (w_taken),
        .exp_pc   (w_exp_pc)
    );

    assign w_checkable = rvfi_valid && !rvfi_trap && w_legal;
    assign w_mismatch  = (w_exp_pc != rvfi_pc_wdata);
    // Only CHECK evaluates; the warm-up-completing retirement is seen in
    // WARMUP and therefore never checked.
    assign w_do_check  = (r_state == ST_CHECK) && w_checkable;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WARMUP: begin
                if (rvfi_valid && (r_wcnt == c_WCNT_LAST)) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_checkable && w_mismatch) begin
                    w_next_state = ST_FAIL;
                end
            end
            ST_FAIL:  w_next_state = ST_FAIL;
            default:  w_next_state = c_RST_STATE;
        endcase
    end

    // Every valid retirement counts toward warm-up, checkable or not
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wcnt <= '0;
        end else if ((r_state == ST_WARMUP) && rvfi_valid) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Statistics and first-error capture. Nothing here moves once the
    // FSM has left CHECK, which freezes everything in FAIL.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
            r_err        <= 1'b0;
            r_err_pc     <= '0;
            r_err_insn   <= '0;
        end else if (w_do_check) begin
            if (r_branch_cnt != {CNT_W{1'b1}}) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_mismatch) begin
                r_err      <= 1'b1;
                r_err_pc   <= rvfi_pc_rdata;
                r_err_insn <= rvfi_insn;
            end
        end
    end

    assign o_armed      = (r_state == ST_CHECK);
    assign o_err        = r_err;
    assign o_err_pc     = r_err_pc;
    assign o_err_insn   = r_err_insn;
    assign o_branch_cnt = r_branch_cnt;
    assign o_taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_branch_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_branch_monitor
// Purpose  : Self-checking bench for rvfi_branch_monitor. A behavioural
//            model produces the expected output snapshot for every cycle;
//            snapshots are queued when stimulus is applied and compared once
//            the DUT has clocked it. A second instance (WARMUP=0, CNT_W=2)
//            covers immediate arming and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_branch_monitor;

    localparam int WU = 4;

    typedef struct {
        logic [31:0] insn;
        logic        trap;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] pcw;
    } ret_t;

    typedef struct packed {
        logic        armed;
        logic        err;
        logic [31:0] epc;
        logic [31:0] einsn;
        logic [15:0] b;
        logic [15:0] t;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst, rst2, v, v2, trap;
    logic [31:0] insn, rs1, rs2, pc, pcw;

    logic        o_armed, o_err;
    logic [31:0] o_err_pc, o_err_insn;
    logic [15:0] o_branch_cnt, o_taken_cnt;

    logic        armed2, err2;
    logic [31:0] epc2, einsn2;
    logic [1:0]  bcnt2, tcnt2;

    exp_t q[$];
    exp_t e, obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    // model state
    int          m_state;
    int          m_wcnt;
    logic        m_err;
    logic [31:0] m_epc, m_einsn;
    logic [15:0] m_b, m_t;

    ret_t IDLE;

    always #5 clk = ~clk;

    rvfi_branch_monitor #(.WARMUP(WU), .CNT_W(16)) dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .rvfi_valid     (v),
        .rvfi_insn      (insn),
        .rvfi_trap      (trap),
        .rvfi_rs1_rdata (rs1),
        .rvfi_rs2_rdata (rs2),
        .rvfi_pc_rdata  (pc),
        .rvfi_pc_wdata  (pcw),
        .o_armed        (o_armed),
        .o_err          (o_err),
        .o_err_pc       (o_err_pc),
        .o_err_insn     (o_err_insn),
        .o_branch_cnt   (o_branch_cnt),
        .o_taken_cnt    (o_taken_cnt)
    );

    rvfi_branch_monitor #(.WARMUP(0), .CNT_W(2)) dut_sat (
        .clk            (clk),
        .i_rst          (rst2),
        .rvfi_valid     (v2),
        .rvfi_insn      (insn),
        .rvfi_trap      (trap),
        .rvfi_rs1_rdata (rs1),
        .rvfi_rs2_rdata (rs2),
        .rvfi_pc_rdata  (pc),
        .rvfi_pc_wdata  (pcw),
        .o_armed        (armed2),
        .o_err          (err2),
        .o_err_pc       (epc2),
        .o_err_insn     (einsn2),
        .o_branch_cnt   (bcnt2),
        .o_taken_cnt    (tcnt2)
    );

    // Build a B-type branch with rs1=x1, rs2=x2
    function automatic logic [31:0] mk_br(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic void model_reset();
        m_state = (WU == 0) ? 1 : 0;
        m_wcnt  = 0;
        m_err   = 1'b0;
        m_epc   = '0;
        m_einsn = '0;
        m_b     = '0;
        m_t     = '0;
    endfunction

    function automatic void model_retire(input ret_t x);
        logic [2:0]  f3;
        logic [31:0] imm, nxt;
        logic        tk;
        f3  = x.insn[14:12];
        imm = {{20{x.insn[31]}}, x.insn[7], x.insn[30:25], x.insn[11:8], 1'b0};
        if (m_state == 0) begin
            m_wcnt = m_wcnt + 1;
            if (m_wcnt == WU) m_state = 1;
        end else if (m_state == 1) begin
            if (!x.trap && x.insn[6:0] == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
                case (f3)
                    3'd0:    tk = (x.rs1 == x.rs2);
                    3'd1:    tk = (x.rs1 != x.rs2);
                    3'd4:    tk = ($signed(x.rs1) <  $signed(x.rs2));
                    3'd5:    tk = ($signed(x.rs1) >= $signed(x.rs2));
                    3'd6:    tk = (x.rs1 <  x.rs2);
                    default: tk = (x.rs1 >= x.rs2);
                endcase
                nxt = tk ? x.pc + imm : x.pc + 32'd4;
                if (m_b != 16'hFFFF) m_b = m_b + 16'd1;
                if (tk && m_t != 16'hFFFF) m_t = m_t + 16'd1;
                if (nxt != x.pcw) begin
                    m_err   = 1'b1;
                    m_epc   = x.pc;
                    m_einsn = x.insn;
                    m_state = 2;
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus (called at a falling edge), queue the
    // model's expected snapshot, return at the next falling edge.
    task automatic step(input logic r, input logic r2, input logic vv,
                        input logic vv2, input ret_t x);
        i_rst = r; rst2 = r2; v = vv; v2 = vv2;
        insn = x.insn; trap = x.trap; rs1 = x.rs1; rs2 = x.rs2;
        pc = x.pc; pcw = x.pcw;
        if (r) model_reset();
        else if (vv) model_retire(x);
        q.push_back({(m_state == 1), m_err, m_epc, m_einsn, m_b, m_t});
        @(negedge clk);
    endtask

    task automatic test_reset();
        ret_t x;
        x = '{mk_br(3'b000, 13'd16), 1'b0, 32'd5, 32'd5, 32'h100, 32'h999};
        step(1'b1, 1'b1, 1'b1, 1'b1, x);   // retirement during reset is dropped
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (o_armed !== 1'b0 || o_err !== 1'b0 || o_branch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_zero: armed=%b err=%b bcnt=%h expected 0/0/0",
                     o_armed, o_err, o_branch_cnt);
        end
        n_checks++;
        if (armed2 !== 1'b1 || bcnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_warmup0: armed=%b bcnt=%h expected 1/0", armed2, bcnt2);
        end
    endtask

    // Four non-checkable retirements back to back finish warm-up
    task automatic test_warmup();
        ret_t tab[4];
        tab[0] = '{32'h00000013, 1'b0, 32'd0, 32'd0, 32'h10, 32'h14};
        tab[1] = '{mk_br(3'b000, 13'd8), 1'b1, 32'd1, 32'd1, 32'h14, 32'h0};
        tab[2] = '{mk_br(3'b010, 13'd8), 1'b0, 32'd1, 32'd1, 32'h18, 32'h0};
        tab[3] = '{32'h00000013, 1'b0, 32'd0, 32'd0, 32'h1C, 32'h20};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, tab[i]);
            e = q.pop_front();
            obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL warmup[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (o_armed !== 1'b1 || o_branch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL warmup_armed: armed=%b bcnt=%h expected 1/0", o_armed, o_branch_cnt);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        e = q.pop_front();
        obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL warmup_idle: got %h expected %h", obs, e);
        end
    endtask

    // Matching branches of every kind, each followed by an idle cycle
    task automatic test_branch_match();
        ret_t tab[5];
        tab[0] = '{mk_br(3'b000, 13'd16), 1'b0, 32'd5, 32'd5, 32'h100, 32'h110};
        tab[1] = '{mk_br(3'b001, 13'd32), 1'b0, 32'd7, 32'd7, 32'h120, 32'h124};
        tab[2] = '{mk_br(3'b101, 13'd8), 1'b0, 32'hFFFFFFFF, 32'd1, 32'h130, 32'h134};
        tab[3] = '{mk_br(3'b111, 13'h1FF0), 1'b0, 32'hFFFFFFFF, 32'd1, 32'h140, 32'h130};
        tab[4] = '{mk_br(3'b110, 13'd8), 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, tab[i]);
            e = q.pop_front();
            obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL match[%0d]: got %h expected %h", i, obs, e);
            end
            if (i == 0) begin
                n_checks++;
                if (o_branch_cnt !== 16'd1 || o_taken_cnt !== 16'd1 || o_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL beq_taken: bcnt=%h tcnt=%h err=%b expected 1/1/0",
                             o_branch_cnt, o_taken_cnt, o_err);
                end
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, IDLE);
            e = q.pop_front();
            obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL match_idle[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (o_err !== 1'b0 || o_branch_cnt !== 16'd5 || o_taken_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL bltu_wrap: err=%b bcnt=%h tcnt=%h expected 0/5/2",
                     o_err, o_branch_cnt, o_taken_cnt);
        end
    endtask

    task automatic test_back_to_back();
        ret_t tab[4];
        tab[0] = '{mk_br(3'b100, 13'd8), 1'b0, 32'd1, 32'd2, 32'h400, 32'h408};
        tab[1] = '{mk_br(3'b001, 13'h1FFC), 1'b0, 32'd1, 32'd2, 32'h408, 32'h404};
        tab[2] = '{mk_br(3'b000, 13'd64), 1'b0, 32'd1, 32'd2, 32'h404, 32'h408};
        tab[3] = IDLE;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, (i < 3), 1'b0, tab[i]);
            e = q.pop_front();
            obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (o_branch_cnt !== 16'd8 || o_taken_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_counts: bcnt=%h tcnt=%h expected 8/4", o_branch_cnt, o_taken_cnt);
        end
    endtask

    task automatic test_fail();
        ret_t x;
        logic [15:0] b_hold, t_hold;
        x = '{mk_br(3'b100, 13'h1FF8), 1'b0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h204};
        step(1'b0, 1'b0, 1'b1, 1'b0, x);
        e = q.pop_front();
        obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL blt_mismatch: got %h expected %h", obs, e);
        end
        n_checks++;
        if (o_err !== 1'b1 || o_err_pc !== 32'h200 || o_armed !== 1'b0) begin
            n_fail++;
            $display("FAIL err_capture: err=%b pc=%h armed=%b expected 1/00000200/0",
                     o_err, o_err_pc, o_armed);
        end
        b_hold = o_branch_cnt;
        t_hold = o_taken_cnt;
        x = '{mk_br(3'b001, 13'd8), 1'b0, 32'd1, 32'd2, 32'h300, 32'h304};
        step(1'b0, 1'b0, 1'b1, 1'b0, x);
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            if (i == 1) begin
                obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL fail_frozen: got %h expected %h", obs, e);
                end
            end
        end
        n_checks++;
        if (o_err_pc !== 32'h200 || o_branch_cnt !== b_hold || o_taken_cnt !== t_hold) begin
            n_fail++;
            $display("FAIL fail_hold: pc=%h bcnt=%h tcnt=%h expected 00000200/%h/%h",
                     o_err_pc, o_branch_cnt, o_taken_cnt, b_hold, t_hold);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, IDLE);
        e = q.pop_front();
        n_checks++;
        if ({o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt} !== 98'd0
            || e !== 98'd0) begin
            n_fail++;
            $display("FAIL fail_reset: got %h expected 0", 
                     {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt});
        end
    endtask

    // Reset mid-warm-up restarts the count; the warm-up-completing branch
    // is not checked even though it mismatches; a not-taken mismatch fails.
    task automatic test_restart();
        ret_t nop, bad0, bad1;
        nop  = '{32'h00000013, 1'b0, 32'd0, 32'd0, 32'h0, 32'h4};
        bad0 = '{mk_br(3'b000, 13'd32), 1'b0, 32'd3, 32'd3, 32'h600, 32'h604};
        bad1 = '{mk_br(3'b000, 13'd32), 1'b0, 32'd1, 32'd2, 32'h500, 32'h520};
        step(1'b0, 1'b0, 1'b1, 1'b0, nop);
        step(1'b0, 1'b0, 1'b1, 1'b0, nop);
        step(1'b1, 1'b0, 1'b1, 1'b0, nop);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, nop);
        step(1'b0, 1'b0, 1'b1, 1'b0, bad0);
        step(1'b0, 1'b0, 1'b1, 1'b0, bad1);
        // drain all but the last two snapshots without inspecting them
        while (q.size() > 2) e = q.pop_front();
        e = q.pop_front();
        n_checks++;
        if (e.armed !== 1'b1 || e.err !== 1'b0 || e.b !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_model: got %h expected armed, no err", e);
        end
        e = q.pop_front();
        obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL restart_notaken: got %h expected %h", obs, e);
        end
        n_checks++;
        if (o_err !== 1'b1 || o_err_pc !== 32'h500 || o_err_insn !== bad1.insn
            || o_branch_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_capture: err=%b pc=%h insn=%h bcnt=%h expected 1/00000500/%h/1",
                     o_err, o_err_pc, o_err_insn, o_branch_cnt, bad1.insn);
        end
    endtask

    task automatic test_saturation();
        ret_t x, tr;
        tr = '{mk_br(3'b000, 13'd16), 1'b1, 32'd5, 32'd5, 32'h100, 32'h110};
        x  = '{mk_br(3'b000, 13'd16), 1'b0, 32'd5, 32'd5, 32'h100, 32'h110};
        step(1'b0, 1'b0, 1'b0, 1'b1, tr);
        e = q.pop_front();
        n_checks++;
        if (bcnt2 !== 2'd0 || err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL trapped_beq: bcnt=%h err=%b expected 0/0", bcnt2, err2);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, x);
            e = q.pop_front();
            n_checks++;
            if (bcnt2 !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
                n_fail++;
                $display("FAIL sat[%0d]: bcnt=%h expected %h", i, bcnt2,
                         (i < 3) ? 2'(i + 1) : 2'd3);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        e = q.pop_front();
        obs = {o_armed, o_err, o_err_pc, o_err_insn, o_branch_cnt, o_taken_cnt};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL sat_main_idle: got %h expected %h", obs, e);
        end
        n_checks++;
        if (bcnt2 !== 2'd3 || tcnt2 !== 2'd3 || err2 !== 1'b0 || armed2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final: bcnt=%h tcnt=%h err=%b armed=%b expected 3/3/0/1",
                     bcnt2, tcnt2, err2, armed2);
        end
    endtask

    initial begin
        IDLE = '{32'h00000013, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
        i_rst = 1'b1; rst2 = 1'b1; v = 1'b0; v2 = 1'b0; trap = 1'b0;
        insn = 32'h13; rs1 = '0; rs2 = '0; pc = '0; pcw = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_warmup();
        test_branch_match();
        test_back_to_back();
        test_fail();
        test_restart();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
